// File: rtl/narrower_18_to_14.sv
// Narrows signed IN_W words to OUT_W with overflow flag/count, buffered by a DEPTH-entry output FIFO.
// Optional macro NARROW_SATURATE_EN: overflowing words saturate instead of wrapping.
module narrower_18_to_14 #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 14,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    logic [OUT_W:0]       mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [OCC_W-1:0]     occ;
    logic [OUT_W:0]       last;
    logic [OUT_W:0]       head;
    logic [IN_W-OUT_W:0]  hi_bits;
    logic                 in_ovf;
    logic [OUT_W-1:0]     narrowed;
    logic                 push;
    logic                 pop;
    logic                 ovf_event;

    assign out_valid = (occ != '0);
    assign in_ready  = (occ < OCC_W'(DEPTH)) & ~rst;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Word fits iff every bit from the output sign position upward is identical.
    assign hi_bits   = in_data[IN_W-1:OUT_W-1];
    assign in_ovf    = ~((&hi_bits) | ~(|hi_bits));
    assign ovf_event = push & in_ovf;

    always_comb begin
        narrowed = in_data[OUT_W-1:0];
`ifdef NARROW_SATURATE_EN
        if (in_ovf) begin
            narrowed = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        narrowed = in_data[OUT_W-1:0];
`endif
    end

    // Empty FIFO presents the most recently popped word rather than a stale slot.
    assign head = mem[rd_ptr];
    assign {out_ovf, out_data} = out_valid ? head : last;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_ovf, narrowed};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            last   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= head;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // A clear coinciding with an overflow accept restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            ovf_count  <= CNT_W'(ovf_event);
            ovf_sticky <= ovf_event;
        end else if (ovf_event) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != {CNT_W{1'b1}}) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_narrower_18_to_14.sv
// Scoreboard bench for narrower_18_to_14: expected words queued on accept, compared on pop.
module tb_narrower_18_to_14;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic        out_ovf;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;
    logic        ovf_clr;

    int total = 0;
    int bad = 0;
    logic [14:0] exp_q[$];
    int   m_count = 0;
    logic m_sticky = 1'b0;

    always #5 clk = ~clk;

    narrower_18_to_14 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count),
        .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference narrowing computed from the signed value range.
    function automatic logic [14:0] model(input logic [17:0] d);
        int v;
        logic ovf;
        logic [13:0] r;
        v   = int'($signed(d));
        ovf = (v > 8191) || (v < -8192);
        r   = d[13:0];
`ifdef NARROW_SATURATE_EN
        if (v > 8191)  r = 14'h1FFF;
        if (v < -8192) r = 14'h2000;
`endif
        return {ovf, r};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                chk("out_data", {18'd0, out_data}, {18'd0, e[13:0]});
                chk("out_ovf", {31'd0, out_ovf}, {31'd0, e[14]});
            end
        end
    end

    // Holds in_valid until accepted (observed at negedge), then drops it after the edge.
    task automatic send(input logic [17:0] d);
        logic [14:0] m;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                m = model(d);
                exp_q.push_back(m);
                if (ovf_clr) begin
                    m_count  = m[14] ? 1 : 0;
                    m_sticky = m[14];
                end else if (m[14]) begin
                    m_sticky = 1'b1;
                    if (m_count < 255) m_count++;
                end
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_counters();
        chk("ovf_count", {24'd0, ovf_count}, m_count);
        chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {18'd0, out_data}, 0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 0);
        @(posedge clk); #1; rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 1);
        check_counters();

        // Basic pass-through and first-word latency
        out_ready = 1'b1;
        send(18'h00123);
        chk("latency_out_valid", {31'd0, out_valid}, 1);
        chk("latency_out_data", {18'd0, out_data}, 32'h0123);
        @(posedge clk); #1;
        chk("hold_out_valid", {31'd0, out_valid}, 0);
        chk("hold_out_data", {18'd0, out_data}, 32'h0123);

        // Boundary values that fit, then overflow in both directions
        send(18'h3FFFF);
        send(18'h3E000);
        send(18'h01FFF);
        send(18'h02000);
        drain();
        check_counters();
        send(18'h3C000);
        send(18'h1FFFF);
        send(18'h20000);
        drain();
        check_counters();

        // Backpressure: two entries fill the FIFO, third waits for a slot
        out_ready = 1'b0;
        send(18'h00AAA);
        send(18'h3F555);
        in_valid = 1'b1;
        in_data  = 18'h00777;
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(18'h00777);
        drain();

        // Randomised traffic with random consumer stalls
        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send(18'($urandom));
        end
        drain();
        check_counters();

        // Saturating counter, then clear racing an overflow accept
        for (int i = 0; i < 300; i++) send(18'h10000 | 18'(i));
        drain();
        check_counters();
        chk("ovf_count_sat", {24'd0, ovf_count}, 255);
        ovf_clr = 1'b1;
        send(18'h2ABCD);
        ovf_clr = 1'b0;
        drain();
        check_counters();
        chk("clr_with_ovf_count", {24'd0, ovf_count}, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        m_count = 0; m_sticky = 1'b0;
        check_counters();

        // Mid-cycle reset with two words buffered
        out_ready = 1'b0;
        send(18'h00011);
        send(18'h02222);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_in_ready", {31'd0, in_ready}, 0);
        chk("midrst_out_data", {18'd0, out_data}, 0);
        exp_q.delete();
        m_count = 0; m_sticky = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        #1;
        chk("postrst_in_ready", {31'd0, in_ready}, 1);
        chk("postrst_out_valid", {31'd0, out_valid}, 0);
        check_counters();
        out_ready = 1'b1;
        send(18'h00042);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
